// File: rtl/kmeans_sample_buffer.sv
`default_nettype none
// ============================================================================
// kmeans_sample_buffer: captures one burst of samples and replays it PASSES
// times on a valid/ready stream. Optional macro: SB_OVERFLOW_EN.
// Revision: 1.0
// ============================================================================
module kmeans_sample_buffer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4096,
  parameter int PASSES = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [AW:0]      count,
  output logic             busy
`ifdef SB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_PLAY = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
`ifdef SB_OVERFLOW_EN
  logic             overflow_q, overflow_d;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             at_last;
  logic             xfer;

  assign at_last = ({1'b0, rd_ptr_q} == (count_q - 1'b1));
  assign xfer    = out_valid_q & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      pass_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef SB_OVERFLOW_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      pass_q      <= pass_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef SB_OVERFLOW_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  // Sample storage is not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    pass_d      = pass_q;
    out_valid_d = out_valid_q;
`ifdef SB_OVERFLOW_EN
    overflow_d  = overflow_q;
`endif
    wr_en       = 1'b0;
    wr_addr     = count_q[AW-1:0];
    rd_en       = 1'b0;
    rd_addr     = rd_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = (AW+1)'(1);
          state_d = S_LOAD;
`ifdef SB_OVERFLOW_EN
          overflow_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (count_q < DEPTH_C) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
`ifdef SB_OVERFLOW_EN
            overflow_d = 1'b1;
`endif
          end
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        rd_en       = 1'b1;
        rd_addr     = '0;
        rd_ptr_d    = '0;
        pass_d      = '0;
        out_valid_d = 1'b1;
        state_d     = S_PLAY;
      end
      S_PLAY: begin
        if (xfer) begin
          if (at_last) begin
            if (pass_q == LAST_PASS) begin
              out_valid_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              pass_d   = pass_q + 1'b1;
              rd_ptr_d = '0;
              rd_en    = 1'b1;
              rd_addr  = '0;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_en    = 1'b1;
            rd_addr  = rd_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // The output word only changes on a prefetch, so it holds during stalls
    out_data_d = rd_en ? mem[rd_addr] : out_data_q;
  end

  // Outputs
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_valid_q & at_last;
    count     = count_q;
    busy      = (state_q != S_IDLE);
`ifdef SB_OVERFLOW_EN
    overflow  = overflow_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_kmeans_sample_buffer.sv
`default_nettype none
// Directed bench for kmeans_sample_buffer: three instances cover the
// main replay, saturation and single-sample configurations.
module tb_kmeans_sample_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: DEPTH=4096, PASSES=2
  logic        a_in_valid, a_out_ready, a_out_valid, a_out_last, a_busy;
  logic [15:0] a_in_data, a_out_data;
  logic [12:0] a_count;
  // Instance B: DEPTH=8, PASSES=1
  logic        b_in_valid, b_out_ready, b_out_valid, b_out_last, b_busy;
  logic [15:0] b_in_data, b_out_data;
  logic [3:0]  b_count;
  // Instance C: DEPTH=16, PASSES=3
  logic        c_in_valid, c_out_ready, c_out_valid, c_out_last, c_busy;
  logic [15:0] c_in_data, c_out_data;
  logic [4:0]  c_count;
`ifdef SB_OVERFLOW_EN
  logic        a_overflow, b_overflow, c_overflow;
`endif

  kmeans_sample_buffer #(.WIDTH(16), .DEPTH(4096), .PASSES(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .out_ready(a_out_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_last(a_out_last), .count(a_count), .busy(a_busy)
`ifdef SB_OVERFLOW_EN
    , .overflow(a_overflow)
`endif
  );

  kmeans_sample_buffer #(.WIDTH(16), .DEPTH(8), .PASSES(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_last(b_out_last), .count(b_count), .busy(b_busy)
`ifdef SB_OVERFLOW_EN
    , .overflow(b_overflow)
`endif
  );

  kmeans_sample_buffer #(.WIDTH(16), .DEPTH(16), .PASSES(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data),
    .out_ready(c_out_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_last(c_out_last), .count(c_count), .busy(c_busy)
`ifdef SB_OVERFLOW_EN
    , .overflow(c_overflow)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_a [4] = '{16'd1024, 16'd512, 16'd1024, 16'd512};
  logic        exp_l [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] d0, input logic [15:0] d1);
    a_in_valid = 1'b1;
    a_in_data  = d0;
    tick();
    a_in_data  = d1;
    tick();
    a_in_valid = 1'b0;
    a_in_data  = '0;
  endtask

  // Stimulus helper: advances until the selected instance shows out_valid
  task automatic wait_valid(input int which, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((which == 0 && a_out_valid) || (which == 1 && b_out_valid) ||
          (which == 2 && c_out_valid)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
    tick();
    tick();
    rst = 1'b0;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); else n_pass++;
    n_total++; if (a_out_data !== 16'd0) $display("FAIL reset_out_data: got %0d expected 0", a_out_data); else n_pass++;
    n_total++; if (a_out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", a_out_last); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", a_busy); else n_pass++;
    n_total++; if (a_count !== 13'd0) $display("FAIL reset_count: got %0d expected 0", a_count); else n_pass++;
    n_total++; if (b_count !== 4'd0) $display("FAIL reset_count_b: got %0d expected 0", b_count); else n_pass++;
`ifdef SB_OVERFLOW_EN
    n_total++; if (b_overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", b_overflow); else n_pass++;
`endif
  endtask

  task automatic test_basic();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 16'd1024;
    tick();
    n_total++; if (a_count !== 13'd1) $display("FAIL basic_count1: got %0d expected 1", a_count); else n_pass++;
    n_total++; if (a_busy !== 1'b1) $display("FAIL basic_busy_load: got %b expected 1", a_busy); else n_pass++;
    a_in_data = 16'd512;
    tick();
    a_in_valid = 1'b0;
    a_in_data  = '0;
    tick();
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL basic_gap_valid: got %b expected 0", a_out_valid); else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (a_out_valid !== 1'b1) $display("FAIL basic_valid[%0d]: got %b expected 1", i, a_out_valid); else n_pass++;
      n_total++; if (a_out_data !== exp_a[i]) $display("FAIL basic_data[%0d]: got %0d expected %0d", i, a_out_data, exp_a[i]); else n_pass++;
      n_total++; if (a_out_last !== exp_l[i]) $display("FAIL basic_last[%0d]: got %b expected %b", i, a_out_last, exp_l[i]); else n_pass++;
      tick();
    end
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL basic_end_valid: got %b expected 0", a_out_valid); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL basic_end_busy: got %b expected 0", a_busy); else n_pass++;
    n_total++; if (a_count !== 13'd2) $display("FAIL basic_count: got %0d expected 2", a_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic pat [3] = '{1'b1, 1'b0, 1'b0};
    logic r;
    int   idx = 0;
    int   k   = 0;
    a_out_ready = 1'b0;
    load_a(16'd1024, 16'd512);
    for (int cyc = 0; cyc < 60 && idx < 4; cyc++) begin
      if (a_out_valid) begin
        r = pat[k % 3];
        k++;
        a_out_ready = r;
        n_total++; if (a_out_data !== exp_a[idx]) $display("FAIL bp_data[%0d]: got %0d expected %0d", idx, a_out_data, exp_a[idx]); else n_pass++;
        n_total++; if (a_out_last !== exp_l[idx]) $display("FAIL bp_last[%0d]: got %b expected %b", idx, a_out_last, exp_l[idx]); else n_pass++;
        if (r) idx++;
      end else begin
        a_out_ready = 1'b0;
      end
      tick();
    end
    a_out_ready = 1'b0;
    n_total++; if (idx !== 4) $display("FAIL bp_transfers: got %0d expected 4", idx); else n_pass++;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL bp_end_valid: got %b expected 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_play();
    logic ok;
    logic [15:0] e;
    a_out_ready = 1'b1;
    load_a(16'd1024, 16'd512);
    wait_valid(0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL rmp_wait1: got %b expected 1", ok); else n_pass++;
    tick(); tick(); tick();
    n_total++; if (a_out_data !== 16'd512) $display("FAIL rmp_pending: got %0d expected 512", a_out_data); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL rmp_valid: got %b expected 0", a_out_valid); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL rmp_busy: got %b expected 0", a_busy); else n_pass++;
    n_total++; if (a_count !== 13'd0) $display("FAIL rmp_count: got %0d expected 0", a_count); else n_pass++;
    load_a(16'd7, 16'd8);
    wait_valid(0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL rmp_wait2: got %b expected 1", ok); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 0) ? 16'd7 : 16'd8;
      n_total++; if (a_out_data !== e) $display("FAIL rmp_data[%0d]: got %0d expected %0d", i, a_out_data, e); else n_pass++;
      n_total++; if (a_out_last !== exp_l[i]) $display("FAIL rmp_last[%0d]: got %b expected %b", i, a_out_last, exp_l[i]); else n_pass++;
      tick();
    end
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL rmp_end_valid: got %b expected 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_in_valid_during_play();
    logic ok;
    a_out_ready = 1'b0;
    load_a(16'd1024, 16'd512);
    wait_valid(0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL ivp_wait: got %b expected 1", ok); else n_pass++;
    a_in_valid = 1'b1;
    a_in_data  = 16'hFFFF;
    tick(); tick(); tick();
    a_in_valid = 1'b0;
    a_in_data  = '0;
    n_total++; if (a_count !== 13'd2) $display("FAIL ivp_count_mid: got %0d expected 2", a_count); else n_pass++;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (a_out_data !== exp_a[i]) $display("FAIL ivp_data[%0d]: got %0d expected %0d", i, a_out_data, exp_a[i]); else n_pass++;
      tick();
    end
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL ivp_end_valid: got %b expected 0", a_out_valid); else n_pass++;
    n_total++; if (a_count !== 13'd2) $display("FAIL ivp_count: got %0d expected 2", a_count); else n_pass++;
    a_out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic ok;
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_in_data = 16'(i);
      tick();
`ifdef SB_OVERFLOW_EN
      if (i == 7) begin
        n_total++; if (b_overflow !== 1'b0) $display("FAIL ovf_before: got %b expected 0", b_overflow); else n_pass++;
      end
      if (i == 8) begin
        n_total++; if (b_overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", b_overflow); else n_pass++;
      end
`endif
    end
    b_in_valid = 1'b0;
    b_in_data  = '0;
    n_total++; if (b_count !== 4'd8) $display("FAIL ovf_count: got %0d expected 8", b_count); else n_pass++;
    b_out_ready = 1'b1;
    wait_valid(1, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL ovf_wait: got %b expected 1", ok); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (b_out_data !== 16'(i)) $display("FAIL ovf_data[%0d]: got %0d expected %0d", i, b_out_data, i); else n_pass++;
      n_total++; if (b_out_last !== (i == 7)) $display("FAIL ovf_last[%0d]: got %b expected %b", i, b_out_last, (i == 7)); else n_pass++;
      tick();
    end
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL ovf_end_valid: got %b expected 0", b_out_valid); else n_pass++;
`ifdef SB_OVERFLOW_EN
    n_total++; if (b_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", b_overflow); else n_pass++;
`endif
  endtask

  task automatic test_single();
    logic ok;
    c_in_valid  = 1'b1;
    c_in_data   = 16'hBEEF;
    tick();
    c_in_valid  = 1'b0;
    c_in_data   = '0;
    c_out_ready = 1'b1;
    wait_valid(2, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL single_wait: got %b expected 1", ok); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (c_out_data !== 16'hBEEF) $display("FAIL single_data[%0d]: got %h expected beef", i, c_out_data); else n_pass++;
      n_total++; if (c_out_last !== 1'b1) $display("FAIL single_last[%0d]: got %b expected 1", i, c_out_last); else n_pass++;
      tick();
    end
    n_total++; if (c_out_valid !== 1'b0) $display("FAIL single_end_valid: got %b expected 0", c_out_valid); else n_pass++;
    n_total++; if (c_count !== 5'd1) $display("FAIL single_count: got %0d expected 1", c_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_play();
    test_in_valid_during_play();
    test_overflow();
    test_single();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
